// File: rtl/id_ex_stage_pkg.sv
// Shared widths, the ID/EX register layout and the bubble value for the
// decode-to-execute pipeline register.
package id_ex_stage_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned CTRL_W     = 8;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 8'h00;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
  } idex_t;

  function automatic idex_t bubble();
    idex_t b;
    b      = '0;
    b.ctrl = BUBBLE_CTRL;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding mux: EX/MEM result beats MEM/WB result beats the
// register file value. Register 0 is forwarded like any other register.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_regwrite,
  input  logic [DATA_W-1:0]     exm_data,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic                  mwb_regwrite,
  input  logic [DATA_W-1:0]     mwb_data,
  output logic [DATA_W-1:0]     fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    if (exm_regwrite && (exm_rd == rs)) begin
      fwd_data = exm_data;
    end else if (mwb_regwrite && (mwb_rd == rs)) begin
      fwd_data = mwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection,
// flush squashing and a saturating count of inserted stall bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_use1,
  input  logic                  in_use2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_regwrite,
  input  logic                  in_memread,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_op1,
  input  logic [DATA_W-1:0]     in_op2,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_regwrite,
  input  logic [DATA_W-1:0]     exm_data,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic                  mwb_regwrite,
  input  logic [DATA_W-1:0]     mwb_data,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_regwrite,
  output logic                  out_memread,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_op1,
  output logic [DATA_W-1:0]     out_op2,
  output logic                  stall_req,
  output logic [15:0]           stall_cnt
);

  idex_t         stage_d, stage_q;
  logic [15:0]   stall_cnt_d, stall_cnt_q;
  logic [DATA_W-1:0] fwd_op1, fwd_op2;
  logic          hazard;

  fwd_mux u_fwd1 (
    .rs           (in_rs1),
    .reg_data     (in_op1),
    .exm_rd       (exm_rd),
    .exm_regwrite (exm_regwrite),
    .exm_data     (exm_data),
    .mwb_rd       (mwb_rd),
    .mwb_regwrite (mwb_regwrite),
    .mwb_data     (mwb_data),
    .fwd_data     (fwd_op1)
  );

  fwd_mux u_fwd2 (
    .rs           (in_rs2),
    .reg_data     (in_op2),
    .exm_rd       (exm_rd),
    .exm_regwrite (exm_regwrite),
    .exm_data     (exm_data),
    .mwb_rd       (mwb_rd),
    .mwb_regwrite (mwb_regwrite),
    .mwb_data     (mwb_data),
    .fwd_data     (fwd_op2)
  );

  // A load sitting in ID/EX cannot be forwarded yet; its consumer must wait one cycle.
  always_comb begin
    hazard = in_valid && stage_q.valid && stage_q.memread && stage_q.regwrite &&
             ((in_use1 && (in_rs1 == stage_q.rd)) || (in_use2 && (in_rs2 == stage_q.rd)));
    stall_req = hazard && !flush && !rst;
  end

  always_comb begin
    stage_d = bubble();
    if (!stall_req && !flush && in_valid) begin
      stage_d.valid    = 1'b1;
      stage_d.rd       = in_rd;
      stage_d.regwrite = in_regwrite;
      stage_d.memread  = in_memread;
      stage_d.ctrl     = in_ctrl;
      stage_d.op1      = fwd_op1;
      stage_d.op2      = fwd_op2;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_req && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= bubble();
      stall_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    out_valid    = stage_q.valid;
    out_rd       = stage_q.rd;
    out_regwrite = stage_q.regwrite;
    out_memread  = stage_q.memread;
    out_ctrl     = stage_q.ctrl;
    out_op1      = stage_q.op1;
    out_op2      = stage_q.op2;
    stall_cnt    = stall_cnt_q;
  end

endmodule
